// File: rtl/nibble_packer_pkg.sv
// Shared constants and helpers for the nibble packer and its siblings in the adder datapath.
package nibble_packer_pkg;

    localparam int unsigned DEF_IN_W  = 4;
    localparam int unsigned DEF_RATIO = 2;

    // Bits needed to represent values 0..value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/nibble_packer_lane_insert.sv
// Writes one lane into a slot of a packed word, optionally clearing every later slot.
module nibble_packer_lane_insert
    import nibble_packer_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned RATIO = DEF_RATIO,
    parameter int unsigned CW    = clog2(DEF_RATIO + 1),
    localparam int unsigned OUT_W = IN_W * RATIO
) (
    input  logic [OUT_W-1:0] word,
    input  logic [IN_W-1:0]  lane,
    input  logic [CW-1:0]    slot,
    input  logic             msb_first,
    input  logic             zero_above,
    output logic [OUT_W-1:0] result
);

    int unsigned pos;

    always_comb begin
        result = word;
        pos    = 0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            // Slot index counts in arrival order; pos is the physical lane position.
            pos = msb_first ? (RATIO - 1 - i) : i;
            if (slot == CW'(i)) begin
                result[pos*IN_W +: IN_W] = lane;
            end else if (zero_above && (CW'(i) > slot)) begin
                result[pos*IN_W +: IN_W] = '0;
            end
        end
    end

endmodule

// File: rtl/nibble_packer.sv
// Packs RATIO consecutive IN_W-bit lanes into one registered OUT_W-bit word with valid/ready.
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter int unsigned IN_W      = DEF_IN_W,
    parameter int unsigned RATIO     = DEF_RATIO,
    parameter int unsigned MSB_FIRST = 1,
    localparam int unsigned OUT_W    = IN_W * RATIO,
    localparam int unsigned CW       = clog2(RATIO + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CW-1:0]    out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] ins_word;
    logic [OUT_W-1:0] out_data_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    out_count_q;
    logic             out_valid_q;
    logic             accept;
    logic             complete;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = in_last || (cnt_q == CW'(RATIO - 1));

    // Slots above cnt are already zero in acc, so one zeroing insert serves both uses.
    nibble_packer_lane_insert #(
        .IN_W  (IN_W),
        .RATIO (RATIO),
        .CW    (CW)
    ) u_lane_insert (
        .word       (acc_q),
        .lane       (in_data),
        .slot       (cnt_q),
        .msb_first  (MSB_FIRST != 0),
        .zero_above (1'b1),
        .result     (ins_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                if (complete) begin
                    out_data_q  <= ins_word;
                    out_count_q <= cnt_q + CW'(1);
                    out_valid_q <= 1'b1;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                end else begin
                    acc_q <= ins_word;
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Bench for nibble_packer: legacy 4+4 table, plus RATIO=4 in both lane orders vs a lane-queue model.
module tb_nibble_packer;

    logic clk;
    logic rst;

    // Instance A: IN_W=4, RATIO=2, MSB_FIRST=1.
    logic [3:0] a_in_data;
    logic       a_in_valid, a_in_last, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_out_data;
    logic [1:0] a_out_count;

    // Instances B (MSB_FIRST=0) and C (MSB_FIRST=1), RATIO=4, share their inputs.
    logic [3:0]  bc_in_data;
    logic        bc_in_valid, bc_in_last, bc_out_ready;
    logic        b_in_ready, b_out_valid, c_in_ready, c_out_valid;
    logic [15:0] b_out_data, c_out_data;
    logic [2:0]  b_out_count, c_out_count;

    int total = 0;
    int bad   = 0;

    nibble_packer #(.IN_W(4), .RATIO(2), .MSB_FIRST(1)) u_a (
        .clk       (clk),
        .rst       (rst),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_last   (a_in_last),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_count (a_out_count),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready)
    );

    nibble_packer #(.IN_W(4), .RATIO(4), .MSB_FIRST(0)) u_b (
        .clk       (clk),
        .rst       (rst),
        .in_data   (bc_in_data),
        .in_valid  (bc_in_valid),
        .in_last   (bc_in_last),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_count (b_out_count),
        .out_valid (b_out_valid),
        .out_ready (bc_out_ready)
    );

    nibble_packer #(.IN_W(4), .RATIO(4), .MSB_FIRST(1)) u_c (
        .clk       (clk),
        .rst       (rst),
        .in_data   (bc_in_data),
        .in_valid  (bc_in_valid),
        .in_last   (bc_in_last),
        .in_ready  (c_in_ready),
        .out_data  (c_out_data),
        .out_count (c_out_count),
        .out_valid (c_out_valid),
        .out_ready (bc_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of legacy-instance stimulus and its expected response.
    typedef struct {
        logic       rst;
        logic [3:0] d;
        logic       v;
        logic       l;
        logic       r;
        logic       rdy;
        logic       ov;
        logic [7:0] data;
        logic [1:0] cnt;
    } a_vec_t;

    a_vec_t av[22];

    // Lane-queue reference model for B/C.
    logic [3:0]  m_lanes[$];
    logic        m_ov;
    logic [15:0] m_b, m_c;
    logic [2:0]  m_cnt;

    task automatic model_reset();
        m_lanes.delete();
        m_ov  = 1'b0;
        m_b   = '0;
        m_c   = '0;
        m_cnt = '0;
    endtask

    task automatic bc_cycle(input logic [3:0] d, input logic v, input logic l, input logic r);
        logic rdy;
        bc_in_data   = d;
        bc_in_valid  = v;
        bc_in_last   = l;
        bc_out_ready = r;
        #1;
        rdy = !m_ov || r;
        check("b_in_ready", b_in_ready, rdy);
        check("c_in_ready", c_in_ready, rdy);
        if (m_ov && r) m_ov = 1'b0;
        if (v && rdy) begin
            m_lanes.push_back(d);
            if (l || m_lanes.size() == 4) begin
                m_b = '0;
                m_c = '0;
                foreach (m_lanes[k]) begin
                    m_b = m_b | (16'(m_lanes[k]) << (4 * k));
                    m_c = m_c | (16'(m_lanes[k]) << (12 - 4 * k));
                end
                m_cnt = 3'(m_lanes.size());
                m_ov  = 1'b1;
                m_lanes.delete();
            end
        end
        @(posedge clk);
        #1;
        check("b_out_valid", b_out_valid, m_ov);
        check("c_out_valid", c_out_valid, m_ov);
        check("b_out_data", b_out_data, m_b);
        check("c_out_data", c_out_data, m_c);
        check("b_out_count", b_out_count, m_cnt);
        check("c_out_count", c_out_count, m_cnt);
    endtask

    initial begin
        // rst d v l r | rdy ov data cnt
        av[0]  = '{0, 4'hA, 1, 0, 1, 1, 0, 8'h00, 2'd0};
        av[1]  = '{0, 4'h5, 1, 0, 1, 1, 1, 8'hA5, 2'd2};
        av[2]  = '{0, 4'h0, 0, 0, 1, 1, 0, 8'hA5, 2'd2};
        av[3]  = '{0, 4'h1, 1, 0, 0, 1, 0, 8'hA5, 2'd2};
        av[4]  = '{0, 4'h2, 1, 0, 0, 1, 1, 8'h12, 2'd2};
        av[5]  = '{0, 4'h3, 1, 0, 0, 0, 1, 8'h12, 2'd2};
        av[6]  = '{0, 4'h3, 1, 0, 0, 0, 1, 8'h12, 2'd2};
        av[7]  = '{0, 4'h3, 1, 0, 0, 0, 1, 8'h12, 2'd2};
        av[8]  = '{0, 4'h3, 1, 0, 0, 0, 1, 8'h12, 2'd2};
        av[9]  = '{0, 4'h3, 1, 0, 0, 0, 1, 8'h12, 2'd2};
        av[10] = '{0, 4'h3, 1, 0, 1, 1, 0, 8'h12, 2'd2};
        av[11] = '{0, 4'h4, 1, 0, 1, 1, 1, 8'h34, 2'd2};
        av[12] = '{0, 4'h6, 1, 1, 1, 1, 1, 8'h60, 2'd1};
        av[13] = '{0, 4'h7, 1, 0, 1, 1, 0, 8'h60, 2'd1};
        av[14] = '{0, 4'h8, 1, 1, 1, 1, 1, 8'h78, 2'd2};
        av[15] = '{0, 4'h9, 1, 0, 1, 1, 0, 8'h78, 2'd2};
        av[16] = '{0, 4'hA, 1, 0, 1, 1, 1, 8'h9A, 2'd2};
        av[17] = '{0, 4'h0, 0, 0, 1, 1, 0, 8'h9A, 2'd2};
        av[18] = '{0, 4'hF, 1, 0, 1, 1, 0, 8'h9A, 2'd2};
        av[19] = '{1, 4'h0, 0, 0, 1, 1, 0, 8'h00, 2'd0};
        av[20] = '{0, 4'h1, 1, 0, 1, 1, 0, 8'h00, 2'd0};
        av[21] = '{0, 4'h2, 1, 0, 1, 1, 1, 8'h12, 2'd2};

        rst          = 1'b1;
        a_in_data    = '0;
        a_in_valid   = 1'b0;
        a_in_last    = 1'b0;
        a_out_ready  = 1'b1;
        bc_in_data   = '0;
        bc_in_valid  = 1'b0;
        bc_in_last   = 1'b0;
        bc_out_ready = 1'b1;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_data", a_out_data, 0);
        check("rst_a_out_count", a_out_count, 0);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_b_out_data", b_out_data, 0);
        check("rst_c_out_count", c_out_count, 0);
        rst = 1'b0;
        #1;
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_b_in_ready", b_in_ready, 1);

        foreach (av[i]) begin
            rst         = av[i].rst;
            a_in_data   = av[i].d;
            a_in_valid  = av[i].v;
            a_in_last   = av[i].l;
            a_out_ready = av[i].r;
            #1;
            check($sformatf("a_in_ready[%0d]", i), a_in_ready, av[i].rdy);
            @(posedge clk);
            #1;
            check($sformatf("a_out_valid[%0d]", i), a_out_valid, av[i].ov);
            check($sformatf("a_out_data[%0d]", i), a_out_data, av[i].data);
            check($sformatf("a_out_count[%0d]", i), a_out_count, av[i].cnt);
        end
        rst        = 1'b0;
        a_in_valid = 1'b0;

        // Fresh start for B/C (the table's mid-word reset also hit them while idle).
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        for (int k = 1; k <= 8; k++) begin
            bc_cycle(4'(k), 1'b1, 1'b0, 1'b1);
            if (k == 4) begin
                check("lsb_word0", b_out_data, 16'h4321);
                check("msb_word0", c_out_data, 16'h1234);
            end
        end
        check("lsb_word1", b_out_data, 16'h8765);
        check("msb_word1", c_out_data, 16'h5678);
        check("lsb_word1_valid", b_out_valid, 1);

        bc_cycle(4'h3, 1'b1, 1'b0, 1'b1);
        bc_cycle(4'h7, 1'b1, 1'b1, 1'b1);
        check("flush_msb_data", c_out_data, 16'h3700);
        check("flush_lsb_data", b_out_data, 16'h0073);
        check("flush_count", c_out_count, 3'd2);
        for (int k = 1; k <= 4; k++) bc_cycle(4'(k), 1'b1, 1'b0, 1'b1);
        check("after_flush_msb", c_out_data, 16'h1234);
        check("after_flush_lsb", b_out_data, 16'h4321);
        check("after_flush_count", b_out_count, 3'd4);

        repeat (600) begin
            bc_cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 7));
        end
        repeat (2) bc_cycle(4'h0, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
